tt_vector_player: RTL and testbench

//   Parametrised self-checking stimulus player for TinyTapeout user projects.

---
 rtl/tt_vector_player.sv | 147 ++++++++++++++
 tb/tb_tt_vector_player.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tt_vector_player.sv
// Vector player: streams stored stimulus onto DUT pins and checks masked uo_out LATENCY cycles later.
// Optional capture RAM of compared uo_out samples when TT_VECTOR_CAPTURE_EN is defined.
module tt_vector_player #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned LATENCY = 1,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [2*WIDTH-1:0]         wr_stim,
   input  logic [WIDTH-1:0]           wr_exp,
   input  logic [WIDTH-1:0]           wr_mask,
   input  logic [$clog2(DEPTH):0]     num_vec,
   input  logic                       start,
   output logic [WIDTH-1:0]           ui_in,
   output logic [WIDTH-1:0]           uio_in,
   input  logic [WIDTH-1:0]           uo_out,
`ifdef TT_VECTOR_CAPTURE_EN
   input  logic [$clog2(DEPTH)-1:0]   cap_addr,
   output logic [WIDTH-1:0]           cap_data,
`endif
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [CNT_W-1:0]           err_count,
   output logic [$clog2(DEPTH)-1:0]   first_err_idx
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned NW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN, S_FIN} state_t;

   state_t state, state_n;

   logic [2*WIDTH-1:0] stim_mem [DEPTH];
   logic [WIDTH-1:0]   exp_mem  [DEPTH];
   logic [WIDTH-1:0]   mask_mem [DEPTH];

   logic [AW-1:0] idx;
   logic [NW-1:0] nvec;
   logic [NW-1:0] num_clamp;
   logic          pipe_v [LATENCY];
   logic [AW-1:0] pipe_k [LATENCY];
   logic [AW-1:0] cmp_k;
   logic          cmp_v;
   logic          miss;
   logic          pend;
   logic          wr_ok;

   always_comb begin
      num_clamp = (num_vec > NW'(DEPTH)) ? NW'(DEPTH) : num_vec;
      cmp_k     = pipe_k[LATENCY-1];
      cmp_v     = pipe_v[LATENCY-1];
      miss      = cmp_v && (((uo_out ^ exp_mem[cmp_k]) & mask_mem[cmp_k]) != '0);
      wr_ok     = wr_en && (state == S_IDLE || state == S_FIN);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Next state; the drain ends once only the entry being compared this cycle is left.
   always_comb begin
      state_n = state;
      pend    = 1'b0;
      for (int i = 0; i < int'(LATENCY) - 1; i++) pend = pend | pipe_v[i];
      case (state)
         S_IDLE:  if (start) state_n = (num_clamp != '0) ? S_PLAY : S_FIN;
         S_PLAY:  if (NW'(idx) == nvec - NW'(1)) state_n = S_DRAIN;
         S_DRAIN: if (!pend) state_n = S_FIN;
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Vector table; never reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         stim_mem[wr_addr] <= wr_stim;
         exp_mem[wr_addr]  <= wr_exp;
         mask_mem[wr_addr] <= wr_mask;
      end
   end

`ifdef TT_VECTOR_CAPTURE_EN
   logic [WIDTH-1:0] cap_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (cmp_v) cap_mem[cmp_k] <= uo_out;
   end

   assign cap_data = cap_mem[cap_addr];
`endif

   // Run control, stimulus drive, index pipe and result tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ui_in         <= '0;
         uio_in        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         first_err_idx <= '0;
         idx           <= '0;
         nvec          <= '0;
         for (int i = 0; i < int'(LATENCY); i++) begin
            pipe_v[i] <= 1'b0;
            pipe_k[i] <= '0;
         end
      end else begin
         done <= (state == S_FIN);
         if (state == S_FIN) busy <= 1'b0;
         if (state == S_IDLE && start) begin
            pass      <= 1'b1;
            err_count <= '0;
            if (num_clamp != '0) begin
               busy <= 1'b1;
               idx  <= '0;
               nvec <= num_clamp;
            end
         end
         if (state == S_PLAY) begin
            {uio_in, ui_in} <= stim_mem[idx];
            idx             <= idx + AW'(1);
         end
         pipe_v[0] <= (state == S_PLAY);
         pipe_k[0] <= idx;
         for (int i = 1; i < int'(LATENCY); i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_k[i] <= pipe_k[i-1];
         end
         if (miss) begin
            pass <= 1'b0;
            if (err_count != {CNT_W{1'b1}}) err_count <= err_count + CNT_W'(1);
            if (pass) first_err_idx <= cmp_k;
         end
      end
   end

endmodule

// File: tb/tb_tt_vector_player.sv
// Directed bench for tt_vector_player with a loopback DUT (uo_out follows the registered ui_in).
// Capture checks compile in when TT_VECTOR_CAPTURE_EN is defined.
module tb_tt_vector_player;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned CNT_W = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [2*WIDTH-1:0] wr_stim;
   logic [WIDTH-1:0]  wr_exp;
   logic [WIDTH-1:0]  wr_mask;
   logic [AW:0]       num_vec;
   logic              start;
   logic [WIDTH-1:0]  ui_in;
   logic [WIDTH-1:0]  uio_in;
   logic [WIDTH-1:0]  uo_out;
   logic              busy;
   logic              done;
   logic              pass;
   logic [CNT_W-1:0]  err_count;
   logic [AW-1:0]     first_err_idx;
`ifdef TT_VECTOR_CAPTURE_EN
   logic [AW-1:0]     cap_addr;
   logic [WIDTH-1:0]  cap_data;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign uo_out = ui_in;

   tt_vector_player #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(1), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_stim(wr_stim),
      .wr_exp(wr_exp), .wr_mask(wr_mask), .num_vec(num_vec), .start(start),
      .ui_in(ui_in), .uio_in(uio_in), .uo_out(uo_out),
`ifdef TT_VECTOR_CAPTURE_EN
      .cap_addr(cap_addr), .cap_data(cap_data),
`endif
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_idx(first_err_idx)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [15:0] s, input logic [7:0] e,
                     input logic [7:0] m);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_stim = s; wr_exp = e; wr_mask = m;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Pulses start and counts negedges after the start edge until done (c=1 is after edge t+1).
   task automatic run(input logic [AW:0] n, input bit disturb, output int cyc,
                      output logic [7:0] ui1);
      cyc = -1;
      ui1 = '0;
      @(negedge clk);
      start = 1'b1; num_vec = n;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) ui1 = ui_in;
         if (disturb) begin
            if (c == 2) begin
               wr_en = 1'b1; wr_addr = '0; wr_stim = '0; wr_exp = 8'h00; wr_mask = 8'hFF;
            end
            if (c == 3) begin start = 1'b1; num_vec = 5'd1; end
            if (c == 4) start = 1'b0;
            if (c == 5) wr_en = 1'b0;
         end
         if (done) begin
            cyc = c;
            break;
         end
      end
   endtask

   initial begin
      int          cyc;
      logic [7:0]  ui1;
      bit          saw_done;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_stim = '0; wr_exp = '0; wr_mask = '0;
      num_vec = '0; start = 1'b0;
`ifdef TT_VECTOR_CAPTURE_EN
      cap_addr = '0;
`endif
      @(negedge clk);
      @(negedge clk);
      chk("rst_ui_in", ui_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_first", first_err_idx, 0);
      rst = 1'b0;

      // Loopback run of four one-hot vectors
      wr(4'd0, 16'h0001, 8'h01, 8'hFF);
      wr(4'd1, 16'h0002, 8'h02, 8'hFF);
      wr(4'd2, 16'h0004, 8'h04, 8'hFF);
      wr(4'd3, 16'h0008, 8'h08, 8'hFF);
      run(5'd4, 1'b0, cyc, ui1);
      chk("t2_done_cyc", cyc, 6);
      chk("t2_first_vec", ui1, 8'h01);
      chk("t2_pass", pass, 1);
      chk("t2_err", err_count, 0);
      chk("t2_busy_at_done", busy, 0);
      @(negedge clk);
      chk("t2_done_pulse", done, 0);
`ifdef TT_VECTOR_CAPTURE_EN
      cap_addr = 4'd3;
      #1;
      chk("t6_cap3", cap_data, 8'h08);
      cap_addr = 4'd1;
      #1;
      chk("t6_cap1", cap_data, 8'h02);
`endif

      // Injected fault on vector 2
      wr(4'd2, 16'h0004, 8'h05, 8'hFF);
      run(5'd4, 1'b0, cyc, ui1);
      chk("t3_done_cyc", cyc, 6);
      chk("t3_pass", pass, 0);
      chk("t3_err", err_count, 1);
      chk("t3_first", first_err_idx, 2);

      // Mask hides the faulty low nibble
      wr(4'd2, 16'h0004, 8'h05, 8'hF0);
      run(5'd4, 1'b0, cyc, ui1);
      chk("t4_mask_pass", pass, 1);
      chk("t4_mask_err", err_count, 0);

      // Empty run finishes immediately
      run(5'd0, 1'b0, cyc, ui1);
      chk("t4_zero_cyc", cyc, 1);
      chk("t4_zero_pass", pass, 1);
      chk("t4_zero_err", err_count, 0);

      // Reset in the middle of PLAY
      @(negedge clk);
      start = 1'b1; num_vec = 5'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("t1_busy_before", busy, 1);
      rst = 1'b1;
      #1;
      chk("t1_ui_in", ui_in, 0);
      chk("t1_busy", busy, 0);
      chk("t1_pass", pass, 0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("t1_no_done", saw_done, 0);
      chk("t1_busy_after", busy, 0);

      // Full table, every vector mismatches; num_vec is clamped to DEPTH
      for (int i = 0; i < int'(DEPTH); i++) wr(AW'(i), {8'h00, 8'(i)}, ~8'(i), 8'hFF);
      run(5'd31, 1'b1, cyc, ui1);
      chk("t5_done_cyc", cyc, 18);
      chk("t5_err_sat", err_count, 3);
      chk("t5_first", first_err_idx, 0);
      chk("t5_pass", pass, 0);
      run(5'd16, 1'b0, cyc, ui1);
      chk("t5_rerun_cyc", cyc, 18);
      chk("t5_rerun_err", err_count, 3);
      chk("t5_rerun_first", first_err_idx, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
